// File: rtl/paver_pkg.sv
// Shared constants and types for the keyboard type-ahead buffer.
// Holds the Ctrl+C key codes and the tagged FIFO entry layout.
package paver_pkg;

  localparam logic [7:0] KEY_CTRL_C_LO = 8'd99;
  localparam logic [7:0] KEY_CTRL_C_UP = 8'd67;

  typedef struct packed {
    logic       ctrl;
    logic [7:0] ch;
  } key_entry_t;

  localparam int KEY_ENTRY_W = $bits(key_entry_t);

  // Ctrl+C is recognised for both the lower- and upper-case letter.
  function automatic logic is_ctrl_c(input logic ctrl, input logic [7:0] ch);
    return ctrl && ((ch == KEY_CTRL_C_LO) || (ch == KEY_CTRL_C_UP));
  endfunction

endpackage

// File: rtl/paver_keybuf_if.sv
// Signal bundle between the PS2 interface / CPU I/O side and the keybuf.
// Handshakes: a key is offered while ps2key!=0 and taken by a one-cycle pickup
// pulse; a FIFO entry is offered while empty=0 and taken by a one-cycle rd_en.
interface paver_keybuf_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]                 ps2key;
  logic                       ctrl_pressed;
  logic                       pickup;
  logic                       rd_en;
  paver_pkg::key_entry_t      rd_data;
  logic                       empty;
  logic                       full;
  logic [AW:0]                count;
  logic                       brk;
  logic                       brk_clr;
  logic                       ovf;
  logic                       ovf_clr;

  modport slave (
    input  ps2key,
    input  ctrl_pressed,
    input  rd_en,
    input  brk_clr,
    input  ovf_clr,
    output pickup,
    output rd_data,
    output empty,
    output full,
    output count,
    output brk,
    output ovf
  );

  modport master (
    output ps2key,
    output ctrl_pressed,
    output rd_en,
    output brk_clr,
    output ovf_clr,
    input  pickup,
    input  rd_data,
    input  empty,
    input  full,
    input  count,
    input  brk,
    input  ovf
  );

endinterface

// File: rtl/paver_fifo.sv
// Generic synchronous FIFO with occupancy count and a flush that wins over
// push and pop; dout is a combinational read of the head entry.
module paver_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only observed while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/paver_keybuf.sv
// Keyboard type-ahead buffer: drains the PS2 holding register into a FIFO,
// flushes on Ctrl+C with a sticky break flag, and flags overwritten keys.
module paver_keybuf
  import paver_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           coreclk,
  input  logic           reset,
  paver_keybuf_if.slave  bus
);

  logic       pickup_q, pickup_d;
  logic       brk_q, brk_d;
  logic       ovf_q, ovf_d;
  logic [7:0] pending_q, pending_d;

  logic       key_pending;
  logic       fifo_full;
  logic       fifo_empty;
  logic       cap;
  logic       ctrl_c;
  logic       push;
  logic       hold_off;
  logic       ovf_set;
  key_entry_t entry;

  assign key_pending = (bus.ps2key != 8'd0);

  // The pickup gate stops the still-visible key from being taken twice.
  assign cap    = key_pending && !pickup_q && !fifo_full;
  assign ctrl_c = cap && is_ctrl_c(bus.ctrl_pressed, bus.ps2key);
  assign push   = cap && !ctrl_c;

  assign entry.ctrl = bus.ctrl_pressed;
  assign entry.ch   = bus.ps2key;

  // While full, remember the waiting key; a different nonzero key means the
  // PS2 side overwrote one we never read.
  assign hold_off = fifo_full && key_pending;
  assign ovf_set  = hold_off && (pending_q != 8'd0) && (bus.ps2key != pending_q);

  always_comb begin
    pickup_d  = cap;
    pending_d = hold_off ? bus.ps2key : 8'd0;
    brk_d     = brk_q;
    ovf_d     = ovf_q;
    if (bus.brk_clr) brk_d = 1'b0;
    if (ctrl_c)      brk_d = 1'b1;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (ovf_set)     ovf_d = 1'b1;
  end

  always_ff @(posedge coreclk) begin
    if (reset) begin
      pickup_q  <= 1'b0;
      brk_q     <= 1'b0;
      ovf_q     <= 1'b0;
      pending_q <= 8'd0;
    end else begin
      pickup_q  <= pickup_d;
      brk_q     <= brk_d;
      ovf_q     <= ovf_d;
      pending_q <= pending_d;
    end
  end

  paver_fifo #(
    .WIDTH (KEY_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (coreclk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (bus.rd_en),
    .flush_i (ctrl_c),
    .din_i   (entry),
    .dout_o  (bus.rd_data),
    .count_o (bus.count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.pickup = pickup_q;
  assign bus.full   = fifo_full;
  assign bus.empty  = fifo_empty;
  assign bus.brk    = brk_q;
  assign bus.ovf    = ovf_q;

endmodule
